// File: rtl/biquad_coeff_loader.sv
// Streams (address, coefficient) pairs from a local table to a biquad block over
// WISHBONE, then issues one update write that latches the new coefficient set.
module biquad_coeff_loader #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        tbl_wr_i,
  input  logic [4:0]  tbl_adr_i,
  input  logic [24:0] tbl_dat_i,
  input  logic        start_i,
  input  logic [5:0]  count_i,
  input  logic        unbypass_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [6:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [5:0]    DEPTH_N  = 6'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, UPDATE, FINISH} state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d, n_q, n_d;
  logic        unb_q, unb_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [6:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;

  logic [24:0] mem [DEPTH];
  logic [24:0] rd_q;
  logic [AW-1:0] rd_adr;
  logic        bus_ok, bus_fail;
  logic        adr_lsb_unused;

  // Table port: writes only while idle; read address follows the next index so
  // the entry is waiting in rd_q during FETCH.
  assign rd_adr = idx_d[AW-1:0];
  always_ff @(posedge wb_clk_i) begin
    if (tbl_wr_i && !busy_q) mem[AW'(tbl_adr_i)] <= tbl_dat_i;
    rd_q <= mem[rd_adr];
  end

  // Target word address keeps only target_adr[6:2]; the byte offset is dropped.
  assign adr_lsb_unused = ^rd_q[19:18];

  // Error or retry wins over a simultaneous ack; timeout fires on the last stb cycle.
  assign bus_fail = stb_q && (wb_err_i || wb_rty_i || (!wb_ack_i && tmo_q == TMO_LAST));
  assign bus_ok   = stb_q && wb_ack_i && !wb_err_i && !wb_rty_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    unb_d   = unb_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    done_d  = 1'b0;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: if (start_i) begin
        n_d     = (count_i > DEPTH_N) ? DEPTH_N : count_i;
        unb_d   = unbypass_i;
        err_d   = 1'b0;
        idx_d   = '0;
        state_d = (n_d != '0) ? FETCH : UPDATE;
      end
      FETCH: begin
        adr_d   = {rd_q[24:20], 2'b00};
        dat_d   = {14'b0, rd_q[17:0]};
        sel_d   = 4'b1111;
        {cyc_d, stb_d, we_d} = 3'b111;
        tmo_d   = '0;
        state_d = WRITE;
      end
      WRITE, UPDATE: begin
        if (state_q == UPDATE && !stb_q) begin
          // First UPDATE cycle keeps the bus idle and sets up the commit write.
          adr_d = 7'h00;
          dat_d = unb_q ? 32'h0001_0001 : 32'h0000_0001;
          sel_d = unb_q ? 4'b0101 : 4'b0001;
          {cyc_d, stb_d, we_d} = 3'b111;
          tmo_d = '0;
        end else if (bus_fail) begin
          {cyc_d, stb_d, we_d} = 3'b000;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (bus_ok) begin
          {cyc_d, stb_d, we_d} = 3'b000;
          if (state_q == WRITE) begin
            idx_d   = idx_q + 6'd1;
            state_d = (idx_d == n_q) ? UPDATE : FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      unb_q   <= 1'b0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      unb_q   <= unb_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Randomized scoreboard bench for biquad_coeff_loader with a bus responder model.
module tb_biquad_coeff_loader;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tbl_wr_i = 1'b0;
  logic [4:0]  tbl_adr_i = '0;
  logic [24:0] tbl_dat_i = '0;
  logic        start_i = 1'b0;
  logic [5:0]  count_i = '0;
  logic        unbypass_i = 1'b0;
  logic        busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [6:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  biquad_coeff_loader dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .tbl_wr_i(tbl_wr_i), .tbl_adr_i(tbl_adr_i),
    .tbl_dat_i(tbl_dat_i), .start_i(start_i), .count_i(count_i), .unbypass_i(unbypass_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  wr_t         exp_q[$];
  logic [24:0] tbl_m [32];
  int checks = 0, failures = 0;
  int done_cnt = 0, last_stb_len = 0;
  // responder configuration: fault kind 0 none, 1 err, 2 rty, 3 never ack
  int ack_dly = 0, fault_idx = 0, fault_kind = 0, wr_no = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: the writes a start should produce, truncated at a faulted write.
  function automatic bit push_expected(int cnt, bit unb, int fidx, int fkind);
    int n = (cnt > 32) ? 32 : cnt;
    int last = n;
    bit faulted = (fkind != 0) && (fidx <= n);
    wr_t w;
    if (faulted) last = fidx;
    for (int i = 0; i <= last; i++) begin
      if (i < n) begin
        w.adr = 7'((tbl_m[i] >> 18) & 25'h7C);
        w.dat = 32'(tbl_m[i] & 25'h3FFFF);
        w.sel = 4'hF;
      end else begin
        w.adr = 7'h00;
        w.dat = unb ? 32'h0001_0001 : 32'h0000_0001;
        w.sel = unb ? 4'b0101 : 4'b0001;
      end
      exp_q.push_back(w);
    end
    return faulted;
  endfunction

  // Responder: acks after ack_dly stb cycles, injects the configured fault,
  // and throws stray acks while stb is low.
  initial begin
    bit stb_seen = 0;
    int wait_c = 0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (rst) begin
        stb_seen = 0;
      end else if (wb_stb_o) begin
        if (!stb_seen) begin stb_seen = 1; wait_c = 0; end
        if (fault_kind != 0 && wr_no == fault_idx) begin
          if (fault_kind == 1) begin
            wb_err_i = 1'b1;
            wb_ack_i = 1'($urandom_range(0, 1));
          end else if (fault_kind == 2) begin
            wb_rty_i = 1'b1;
          end
        end else if (wait_c >= ack_dly) begin
          wb_ack_i = 1'b1;
        end
        wait_c++;
      end else begin
        if (stb_seen) begin stb_seen = 0; wr_no++; end
        wb_ack_i = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: pops the scoreboard at each new write and checks bus stability.
  initial begin
    bit stb_prev = 0;
    int stb_len = 0;
    wr_t cur, w;
    forever begin
      @(negedge clk);
      if (rst) begin
        stb_prev = 0;
      end else begin
        if (done_o) done_cnt++;
        if (wb_stb_o) chk("stb_implies_cyc", wb_cyc_o, 1);
        if (wb_stb_o && !stb_prev) begin
          cur.adr = wb_adr_o; cur.dat = wb_dat_o; cur.sel = wb_sel_o;
          stb_len = 1;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write adr=%0h dat=%0h sel=%0h", wb_adr_o, wb_dat_o, wb_sel_o);
          end else begin
            w = exp_q.pop_front();
            chk("wr_adr", wb_adr_o, w.adr);
            chk("wr_dat", wb_dat_o, w.dat);
            chk("wr_sel", wb_sel_o, w.sel);
            chk("wr_we", wb_we_o, 1);
          end
        end else if (wb_stb_o) begin
          stb_len++;
          chk("wr_hold", {wb_adr_o, wb_dat_o, wb_sel_o}, {cur.adr, cur.dat, cur.sel});
        end
        if (!wb_stb_o && stb_prev) last_stb_len = stb_len;
        stb_prev = wb_stb_o;
      end
    end
  end

  task automatic load(int idx, logic [24:0] d);
    @(negedge clk);
    tbl_wr_i = 1'b1; tbl_adr_i = 5'(idx); tbl_dat_i = d;
    tbl_m[idx] = d;
    @(negedge clk);
    tbl_wr_i = 1'b0;
  endtask

  task automatic run(int cnt, bit unb, int dly, int fidx, int fkind, bit poke);
    int n = (cnt > 32) ? 32 : cnt;
    bit exp_err, ok;
    int d0 = done_cnt;
    exp_err = push_expected(cnt, unb, fidx, fkind);
    ack_dly = dly; fault_idx = fidx; fault_kind = fkind; wr_no = 0;
    @(negedge clk);
    count_i = 6'(cnt); unbypass_i = unb; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    if (poke && n >= 2) begin
      @(negedge clk);
      start_i = 1'b1; count_i = 6'd1; unbypass_i = ~unb;
      tbl_wr_i = 1'b1; tbl_adr_i = 5'd0; tbl_dat_i = ~tbl_m[0];
      @(negedge clk);
      start_i = 1'b0; tbl_wr_i = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!busy_o) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("seq_terminates", ok, 1);
    chk("err_o_end", err_o, exp_err);
    chk("done_pulse_count", done_cnt - d0, exp_err ? 0 : 1);
    chk("writes_outstanding", exp_q.size(), 0);
    if (fkind == 3 && exp_err) chk("timeout_stb_len", last_stb_len, TMO);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int cnt, n, fk;
    #3 rst = 1'b1;
    #4;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    chk("rst_adr_dat_sel", {wb_adr_o, wb_dat_o, wb_sel_o}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) load(i, 25'($urandom));
    load(0, {7'h04, 18'h00123});
    load(1, {7'h08, 18'h3FFFF});
    load(2, {7'h10, 18'h00005});

    run(3, 0, 2, 0, 0, 0);   // basic three-entry load
    run(0, 1, 1, 0, 0, 0);   // update-only with unbypass
    run(3, 0, 1, 1, 3, 0);   // 2nd write never acked
    run(4, 0, 0, 0, 1, 0);   // bus error on 1st write
    run(4, 0, 1, 0, 0, 0);   // restart clears err_o

    for (int k = 0; k < 8; k++) begin
      cnt = $urandom_range(0, 40);
      n = (cnt > 32) ? 32 : cnt;
      fk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run(cnt, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          $urandom_range(0, n), fk, 1'($urandom_range(0, 1)));
    end
    run(2, 0, 0, 0, 0, 0);   // leave err_o clear

    // Reset in the middle of a held write.
    void'(push_expected(5, 0, 0, 0));
    ack_dly = 8; fault_kind = 0; wr_no = 0;
    @(negedge clk);
    count_i = 6'd5; unbypass_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (wb_stb_o) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("stb_before_reset", ok, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done_err", {done_o, err_o}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_err", err_o, 0);
    run(5, 0, 1, 0, 0, 0);   // replay after reset, table intact

    run(40, 1, 0, 0, 0, 1);  // clamp to 32 entries, pokes while busy ignored
    run(3, 0, 0, 0, 0, 0);   // entry 0 unchanged by the busy-time write

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
